// File: rtl/cic_pkg.sv
// Shared CIC helpers: ceiling log2, internal datapath width and FSM state encoding.
package cic_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Worst-case bit growth of an N-stage interpolator at rate lmax, delay m.
  function automatic int unsigned cic_width(input int unsigned dw, input int unsigned n,
                                            input int unsigned lmax, input int unsigned m);
    return dw + n * clog2(lmax * m);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x delayed by M accepted samples, W-bit wrap-around.
module cic_comb_stage #(
  parameter int unsigned W = 26,
  parameter int unsigned M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y_c
);

  logic [W-1:0] dly_q [M];

  assign y_c = x - dly_q[M-1];

  // Delay line advances only when a new input sample is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(M); i++) dly_q[i] <= '0;
    end else if (en) begin
      dly_q[0] <= x;
      for (int i = 1; i < int'(M); i++) dly_q[i] <= dly_q[i-1];
    end
  end

endmodule

// File: rtl/cic_interp_param.sv
// Parameterised CIC interpolator: comb chain at input rate, zero-stuffed integrators at output
// rate, arithmetic gain shift and saturation, ready/valid handshakes on both sides.
module cic_interp_param
  import cic_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned OW   = 8,
  parameter int unsigned N    = 3,
  parameter int unsigned M    = 1,
  parameter int unsigned LMAX = 64,
  parameter int unsigned LW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] L,
  input  logic [5:0]    gain_shift,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] d_out,
  output logic          sat
);

  localparam int unsigned W  = cic_width(DW, N, LMAX, M);
  localparam int unsigned PW = clog2(LMAX) + 1;
  localparam logic [PW-1:0] LMAX_P = PW'(LMAX);

  state_t               state_q, state_d;
  logic [PW-1:0]        phase_q, le_q, le_c;
  logic [W-1:0]         comb_q;
  logic [W-1:0]         comb_v [N+1];
  logic [N-1:0][W-1:0]  integ_q, integ_d;
  logic [W-1:0]         acc_c;
  logic signed [W-1:0]  shifted_c;
  logic [OW-1:0]        sat_val_c;
  logic                 step_c, last_c, accept_c, clip_c;

  // Comb chain, evaluated combinationally and captured into comb_q on acceptance.
  assign comb_v[0] = W'($signed(d_in));

  for (genvar g = 0; g < int'(N); g++) begin : g_comb
    cic_comb_stage #(.W(W), .M(M)) u_comb (
      .clk (clk),
      .rst (rst),
      .en  (accept_c),
      .x   (comb_v[g]),
      .y_c (comb_v[g+1])
    );
  end

  // Effective rate: 0 maps to 1, anything above LMAX clamps to LMAX.
  always_comb begin
    le_c = LMAX_P;
    if (L == '0) le_c = PW'(1);
    else if (32'(L) <= 32'(LMAX)) le_c = PW'(L);
  end

  assign last_c   = (phase_q == PW'(le_q - PW'(1)));
  assign step_c   = (state_q == ST_EMIT) && (!out_valid || out_ready);
  assign in_ready = (state_q == ST_IDLE) || (step_c && last_c);
  assign accept_c = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_EMIT;
      ST_EMIT: if (step_c && last_c && !accept_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Integrator cascade: comb_q enters on phase 0 only, zeros otherwise.
  always_comb begin
    acc_c = (phase_q == '0) ? comb_q : '0;
    for (int i = 0; i < int'(N); i++) begin
      integ_d[i] = integ_q[i] + acc_c;
      acc_c      = integ_d[i];
    end
  end

  assign shifted_c = $signed(integ_d[N-1]) >>> gain_shift;

  if (W > OW) begin : g_clamp
    logic [W-OW:0] top_c;
    assign top_c = shifted_c[W-1:OW-1];
    always_comb begin
      clip_c    = 1'b0;
      sat_val_c = shifted_c[OW-1:0];
      if (shifted_c[W-1] && !(&top_c)) begin
        clip_c    = 1'b1;
        sat_val_c = {1'b1, {(OW-1){1'b0}}};
      end else if (!shifted_c[W-1] && (|top_c)) begin
        clip_c    = 1'b1;
        sat_val_c = {1'b0, {(OW-1){1'b1}}};
      end
    end
  end else begin : g_wide
    assign clip_c    = 1'b0;
    assign sat_val_c = OW'(shifted_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= '0;
      le_q      <= PW'(1);
      comb_q    <= '0;
      integ_q   <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (accept_c) begin
        comb_q <= comb_v[N];
        le_q   <= le_c;
      end
      if (step_c) begin
        integ_q   <= integ_d;
        d_out     <= sat_val_c;
        out_valid <= 1'b1;
        if (clip_c) sat <= 1'b1;
        phase_q   <= last_c ? '0 : PW'(phase_q + PW'(1));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_interp_param.sv
// Bench for cic_interp_param: two instances (OW=16 and OW=8) on shared stimulus, checked
// against a sample-level behavioural model plus directed literal expectations.
module tb_cic_interp_param;

  localparam int W = 26;  // 8 + 3*log2(64)
  localparam longint MASK = (64'sd1 <<< W) - 64'sd1;

  logic        clk, rst;
  logic [15:0] L;
  logic [5:0]  gain_shift;
  logic        in_valid, out_ready;
  logic [7:0]  d_in;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, sat_a, sat_b;
  logic [15:0] d_out_a;
  logic [7:0]  d_out_b;

  cic_interp_param #(.DW(8), .OW(16), .N(3), .M(1), .LMAX(64), .LW(16)) dut_a (
    .clk(clk), .rst(rst), .L(L), .gain_shift(gain_shift),
    .in_valid(in_valid), .in_ready(in_ready_a), .d_in(d_in),
    .out_valid(out_valid_a), .out_ready(out_ready), .d_out(d_out_a), .sat(sat_a)
  );

  cic_interp_param #(.DW(8), .OW(8), .N(3), .M(1), .LMAX(64), .LW(16)) dut_b (
    .clk(clk), .rst(rst), .L(L), .gain_shift(gain_shift),
    .in_valid(in_valid), .in_ready(in_ready_b), .d_in(d_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .d_out(d_out_b), .sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint a;
    longint b;
    bit     sa;
    bit     sb;
  } exp_t;

  exp_t   exp_q[$];
  longint log_a[$];
  longint log_b[$];
  longint hist[4];
  longint acc[3];
  bit     msat_a, msat_b;
  bit     hold_pend;
  longint held_a, held_b;

  function automatic longint sext(input longint v);
    return (v <<< (64 - W)) >>> (64 - W);
  endfunction

  function automatic longint clamp(input longint s, input int ow);
    longint hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    for (int i = 0; i < 3; i++) acc[i] = 0;
    msat_a = 0;
    msat_b = 0;
    hold_pend = 0;
    exp_q.delete();
  endtask

  // One accepted sample produces Le output samples of the upsampled, filtered stream.
  task automatic model_accept(input longint x, input int unsigned lval, input int sh);
    int     le;
    longint c, v, s;
    exp_t   e;
    le = (lval == 0) ? 1 : ((lval > 64) ? 64 : int'(lval));
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    c = hist[0] - 3 * hist[1] + 3 * hist[2] - hist[3];
    for (int p = 0; p < le; p++) begin
      v = (p == 0) ? c : 0;
      for (int i = 0; i < 3; i++) begin
        acc[i] = (acc[i] + v) & MASK;
        v = acc[i];
      end
      s = sext(acc[2]) >>> sh;
      e.a = clamp(s, 16);
      e.b = clamp(s, 8);
      if (e.a != s) msat_a = 1;
      if (e.b != s) msat_b = 1;
      e.sa = msat_a;
      e.sb = msat_b;
      exp_q.push_back(e);
    end
  endtask

  // Compare process: handshake agreement, hold stability, and every transferred sample.
  always @(negedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      check("in_ready_match", in_ready_b, in_ready_a);
      check("out_valid_match", out_valid_b, out_valid_a);
      if (hold_pend) begin
        check("hold_valid", out_valid_a, 1);
        check("hold_d_out_a", longint'($signed(d_out_a)), held_a);
        check("hold_d_out_b", longint'($signed(d_out_b)), held_b);
      end
      hold_pend = out_valid_a && !out_ready;
      held_a = longint'($signed(d_out_a));
      held_b = longint'($signed(d_out_b));
      if (out_valid_a && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got %0d expected none", $signed(d_out_a));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("d_out_a", longint'($signed(d_out_a)), e.a);
          check("d_out_b", longint'($signed(d_out_b)), e.b);
          check("sat_a", sat_a, e.sa);
          check("sat_b", sat_b, e.sb);
        end
        log_a.push_back(longint'($signed(d_out_a)));
        log_b.push_back(longint'($signed(d_out_b)));
      end
      if (in_valid && in_ready_a)
        model_accept(longint'($signed(d_in)), int'(L), int'(gain_shift));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] x, output int waited);
    in_valid = 1'b1;
    d_in     = x;
    waited   = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (in_ready_a) break;
      if (waited >= 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready 0 after %0d cycles expected 1", waited);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid_a && in_ready_a) break;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send_n(input logic [7:0] x, input int n);
    int w;
    for (int i = 0; i < n; i++) send(x, w);
  endtask

  // Impulse response with L=4, checking first-output latency and one input per Le cycles.
  task automatic impulse();
    int w;
    longint imp[16];
    imp = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0, 0, 0, 0, 0, 0};
    L = 16'd4;
    gain_shift = 6'd0;
    out_ready = 1'b1;
    log_a.delete();
    send(8'd1, w);
    check("lat_valid_low", out_valid_a, 0);
    @(posedge clk);
    #1;
    check("lat_valid_high", out_valid_a, 1);
    check("lat_first_d_out", longint'($signed(d_out_a)), 1);
    send(8'd0, w);
    check("rate_wait_2", w, 3);
    send(8'd0, w);
    check("rate_wait_3", w, 4);
    send(8'd0, w);
    check("rate_wait_4", w, 4);
    drain();
    check("impulse_count", log_a.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < log_a.size()) check($sformatf("impulse_%0d", i), log_a[i], imp[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    logic [7:0] held;
    rst = 1'b0;
    L = 16'd4;
    gain_shift = 6'd0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    d_in = 8'd0;
    #2;
    check("rst_d_out", longint'(d_out_a), 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_sat", sat_b, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_in_ready", in_ready_a, 1);

    impulse();

    // DC gain: (L*M)^N / L = 16 at L=4.
    do_reset();
    L = 16'd4; gain_shift = 6'd0; log_a.delete();
    send_n(8'd1, 8);
    drain();
    for (int i = 28; i < 32; i++) check("dc_shift0", log_a[i], 16);
    do_reset();
    gain_shift = 6'd4; log_a.delete();
    send_n(8'd1, 8);
    drain();
    for (int i = 28; i < 32; i++) check("dc_shift4", log_a[i], 1);
    do_reset();
    L = 16'd0; gain_shift = 6'd0; log_a.delete();
    send_n(8'd5, 4);
    drain();
    check("l0_count", log_a.size(), 4);
    for (int i = 0; i < 4; i++) if (i < log_a.size()) check("l0_passthrough", log_a[i], 5);

    // Saturation at both rails on the OW=8 instance.
    do_reset();
    L = 16'd4; log_a.delete(); log_b.delete();
    send_n(8'd127, 8);
    drain();
    check("sat_pos_b", log_b[31], 127);
    check("sat_pos_a", log_a[31], 2032);
    check("sat_flag_b", sat_b, 1);
    check("sat_flag_a", sat_a, 0);
    do_reset();
    check("sat_cleared", sat_b, 0);
    log_a.delete(); log_b.delete();
    send_n(8'h80, 8);
    drain();
    check("sat_neg_b", log_b[31], -128);
    check("sat_neg_a", log_a[31], -2048);
    check("sat_flag_neg", sat_b, 1);

    // Backpressure mid-EMIT.
    do_reset();
    L = 16'd8; gain_shift = 6'd0;
    send(8'd50, w);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    held = d_out_b;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid_a, 1);
      check("bp_d_out", longint'(d_out_b), longint'(held));
      check("bp_in_ready", in_ready_a, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'hEC, w);
    send(8'd7, w);
    drain();

    // Reset in phase 2 aborts the sample; next impulse is clean.
    do_reset();
    L = 16'd4; gain_shift = 6'd0;
    send(8'd1, w);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_d_out", longint'(d_out_a), 0);
    check("mid_rst_valid", out_valid_a, 0);
    check("mid_rst_sat", sat_a, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mid_rst_in_ready", in_ready_a, 1);
    impulse();

    // Randomised traffic, rate and backpressure; gain_shift changes only between segments.
    for (int seg = 0; seg < 6; seg++) begin
      gain_shift = 6'($urandom_range(0, 12));
      for (int c = 0; c < 500; c++) begin
        @(posedge clk);
        #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        d_in      = 8'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 5))
          0:       L = 16'd0;
          1:       L = 16'($urandom_range(65, 1000));
          2:       L = 16'hFFFF;
          default: L = 16'($urandom_range(1, 64));
        endcase
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
